// File: rtl/gray_seq_pkg.sv
// Shared types and Gray-code helpers for the gray_seq_ctrl slice.
// The sequence index maps to the code as reflected binary: gray = idx ^ (idx >> 1).
package gray_seq_pkg;

    typedef enum logic [1:0] {
        OP_STEP_UP = 2'b00,
        OP_STEP_DN = 2'b01,
        OP_GOTO    = 2'b10,
        OP_NOP     = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [2:0] gray_to_idx(input logic [2:0] g);
        logic [2:0] idx;
        idx[2] = g[2];
        idx[1] = idx[2] ^ g[1];
        idx[0] = idx[1] ^ g[0];
        return idx;
    endfunction

    function automatic logic [2:0] idx_to_gray(input logic [2:0] idx);
        return idx ^ (idx >> 1);
    endfunction

    function automatic logic [2:0] gray_next(input logic [2:0] g);
        return idx_to_gray(gray_to_idx(g) + 3'd1);
    endfunction

    function automatic logic [2:0] gray_prev(input logic [2:0] g);
        return idx_to_gray(gray_to_idx(g) - 3'd1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_stepper.sv
// 3-bit Gray position register; moves one code per step, up when dir=1.
module gray3_stepper
    import gray_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       dir,
    output logic [2:0] gray
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray <= 3'b000;
        end else if (step) begin
            gray <= dir ? gray_next(gray) : gray_prev(gray);
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven Gray position sequencer with dwell pacing and abort.
// Define GRAY_SEQ_CTRL_GOTO_EN to compile in shortest-path GOTO; otherwise GOTO acts as NOP.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | waiting for a command, cmd_ready=1
//   ST_RUN  | dwell/step loop until remaining hits 0 or abort
//   ST_DONE | one-cycle completion pulse, then back to idle
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int N_W   = 8,
    parameter int DWELL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [N_W-1:0] cmd_arg,
    input  logic           abort,
    output logic [2:0]     gray,
    output logic           step_stb,
    output logic           busy,
    output logic           done,
    output logic           aborted
);

    localparam int DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW_W-1:0] DWELL_V = DW_W'(DWELL);

    state_e          state, state_nxt;
    logic [N_W-1:0]  remaining;
    logic [DW_W-1:0] dwell_cnt;
    logic            dir;
    logic            abort_q;
    logic            step;
    logic            start_up;
    logic [N_W-1:0]  start_rem;
    logic            accept;
    op_e             op;

    assign op     = op_e'(cmd_op);
    assign accept = (state == ST_IDLE) && cmd_valid;
    assign step   = (state == ST_RUN) && !abort && (dwell_cnt == '0);

`ifdef GRAY_SEQ_CTRL_GOTO_EN
    logic [2:0] goto_dist;
    logic [2:0] goto_back;
    assign goto_dist = gray_to_idx(cmd_arg[2:0]) - gray_to_idx(gray);
    assign goto_back = 3'd0 - goto_dist;
`endif

    // Decode the offered command into direction and step count; zero means no RUN.
    always_comb begin
        start_up  = 1'b1;
        start_rem = '0;
        case (op)
            OP_STEP_UP: begin
                start_up  = 1'b1;
                start_rem = cmd_arg;
            end
            OP_STEP_DN: begin
                start_up  = 1'b0;
                start_rem = cmd_arg;
            end
`ifdef GRAY_SEQ_CTRL_GOTO_EN
            OP_GOTO: begin
                if (goto_dist <= 3'd4) begin
                    start_up  = 1'b1;
                    start_rem = N_W'(goto_dist);
                end else begin
                    start_up  = 1'b0;
                    start_rem = N_W'(goto_back);
                end
            end
`endif
            default: begin
                start_up  = 1'b1;
                start_rem = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (start_rem != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (step && (remaining == N_W'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        aborted   = (state == ST_DONE) && abort_q;
    end

    // Dwell is a down-counter reloaded on every step; a step fires at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            dwell_cnt <= '0;
            dir       <= 1'b0;
            abort_q   <= 1'b0;
            step_stb  <= 1'b0;
        end else begin
            step_stb <= step;
            if (accept) begin
                remaining <= start_rem;
                dir       <= start_up;
                dwell_cnt <= DWELL_V;
                abort_q   <= 1'b0;
            end else if (state == ST_RUN) begin
                if (abort) begin
                    abort_q <= 1'b1;
                end else if (dwell_cnt == '0) begin
                    dwell_cnt <= DWELL_V;
                    remaining <= remaining - 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt - 1'b1;
                end
            end
        end
    end

    gray3_stepper u_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .dir   (dir),
        .gray  (gray)
    );

endmodule
